// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage scoreboard hazard unit.
package hazard_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int MAX_LAT_DEF  = 4;
    localparam int LAT_W_DEF    = $clog2(MAX_LAT_DEF + 1);

    typedef logic [4:0]           regaddr_t;
    typedef logic [LAT_W_DEF-1:0] lat_t;

    // Latencies beyond what the counters can represent are treated as the maximum.
    function automatic int clamp_lat(int lat, int max_lat);
        return (lat > max_lat) ? max_lat : lat;
    endfunction

endpackage

// File: rtl/hazard_sb_counter.sv
// Per-register countdown to writeback: load on issue, otherwise decrement to zero.
module hazard_sb_counter #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] cnt,
    output logic             busy,
    output logic             busy_nxt
);

    logic [LAT_W-1:0] cnt_nxt;

    // A fresh issue overrides the decrement of the same entry.
    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = load_val;
        end else if (cnt != '0) begin
            cnt_nxt = cnt - LAT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign busy     = (cnt != '0);
    assign busy_nxt = (cnt_nxt != '0);

endmodule

// File: rtl/id_scoreboard_hazard.sv
// ID-stage operand hazard unit: tracks cycles until each register's producer
// reaches W, raising RAW/WAW decode stalls and W-bypass selects.
module id_scoreboard_hazard
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int MAX_LAT  = MAX_LAT_DEF,
    parameter int PERF_W   = 16,
    localparam int LAT_W   = $clog2(MAX_LAT + 1),
    localparam int PC_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid_D,
    input  logic                 reg_write_D,
    input  regaddr_t             rd_D,
    input  logic [LAT_W-1:0]     lat_D,
    input  logic [NUM_SRC*5-1:0] rs_D,
    input  logic [NUM_SRC-1:0]   rs_used_D,
    input  logic                 flush_D,
    input  logic                 RegWrite_W,
    input  regaddr_t             rd_W,
    output logic [NUM_SRC-1:0]   ForwardID,
    output logic                 stall_D,
    output logic [PC_W-1:0]      pending_cnt,
    output logic [PERF_W-1:0]    stall_cycles
);

    logic [LAT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [LAT_W-1:0]    lat_eff;
    logic [NUM_SRC-1:0]  raw_hit;
    logic [NUM_SRC-1:0]  fwd;
    logic                waw;
    logic                issue;
    logic [PC_W-1:0]     pend_nxt;

    assign lat_eff = LAT_W'(clamp_lat(int'(lat_D), MAX_LAT));

    // x0 never has a pending write.
    assign cnt[0]      = '0;
    assign busy[0]     = 1'b0;
    assign busy_nxt[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        hazard_sb_counter #(.LAT_W(LAT_W)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .load     (issue && (rd_D == regaddr_t'(r))),
            .load_val (lat_eff),
            .cnt      (cnt[r]),
            .busy     (busy[r]),
            .busy_nxt (busy_nxt[r])
        );
    end

    // Per-source RAW hit and W-bypass select.
    always_comb begin
        regaddr_t src;
        src     = '0;
        raw_hit = '0;
        fwd     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src        = rs_D[i*5 +: 5];
            raw_hit[i] = rs_used_D[i] && (src != '0) && (cnt[src] > LAT_W'(1));
            fwd[i]     = RegWrite_W && (rd_W != '0) && (rd_W == src) && rs_used_D[i];
        end
    end

    // A younger write must not land in W before an older write to the same rd.
    assign waw = reg_write_D && (rd_D != '0) && (lat_eff != '0) && busy[rd_D]
                 && (lat_eff < cnt[rd_D]);

    assign stall_D   = !rst && issue_valid_D && !flush_D && ((|raw_hit) || waw);
    assign ForwardID = rst ? '0 : fwd;

    assign issue = issue_valid_D && !flush_D && !stall_D && reg_write_D
                   && (rd_D != '0) && (lat_eff != '0);

    // Popcount of next-cycle busy flags so pending_cnt lines up with the counters.
    always_comb begin
        pend_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_nxt = pend_nxt + PC_W'(busy_nxt[r]);
        end
    end

    // Registered pending count and saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_cnt  <= '0;
            stall_cycles <= '0;
        end else begin
            pending_cnt <= pend_nxt;
            if (stall_D && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_scoreboard_hazard.sv
// Scoreboard bench for id_scoreboard_hazard: directed cycles push expectations,
// a negedge monitor pops and compares them.
module tb_id_scoreboard_hazard;

    logic        clk = 1'b0;
    logic        rst;

    // main instance: MAX_LAT = 4, PERF_W = 16
    logic        issue_valid_D, reg_write_D, flush_D, RegWrite_W;
    logic [4:0]  rd_D, rd_W;
    logic [2:0]  lat_D;
    logic [9:0]  rs_D;
    logic [1:0]  rs_used_D;
    logic [1:0]  ForwardID;
    logic        stall_D;
    logic [5:0]  pending_cnt;
    logic [15:0] stall_cycles;

    // perf instance: MAX_LAT = 31, PERF_W = 4
    logic        p_iv, p_rw, p_fl, p_rww;
    logic [4:0]  p_rd, p_rdw;
    logic [4:0]  p_lat;
    logic [9:0]  p_rs;
    logic [1:0]  p_used;
    logic [1:0]  p_fwd;
    logic        p_stall;
    logic [5:0]  p_pend;
    logic [3:0]  p_sc;

    id_scoreboard_hazard #(.NUM_SRC(2), .NUM_REGS(32), .MAX_LAT(4), .PERF_W(16)) dut (
        .clk(clk), .rst(rst), .issue_valid_D(issue_valid_D), .reg_write_D(reg_write_D),
        .rd_D(rd_D), .lat_D(lat_D), .rs_D(rs_D), .rs_used_D(rs_used_D), .flush_D(flush_D),
        .RegWrite_W(RegWrite_W), .rd_W(rd_W), .ForwardID(ForwardID), .stall_D(stall_D),
        .pending_cnt(pending_cnt), .stall_cycles(stall_cycles)
    );

    id_scoreboard_hazard #(.NUM_SRC(2), .NUM_REGS(32), .MAX_LAT(31), .PERF_W(4)) dut2 (
        .clk(clk), .rst(rst), .issue_valid_D(p_iv), .reg_write_D(p_rw),
        .rd_D(p_rd), .lat_D(p_lat), .rs_D(p_rs), .rs_used_D(p_used), .flush_D(p_fl),
        .RegWrite_W(p_rww), .rd_W(p_rdw), .ForwardID(p_fwd), .stall_D(p_stall),
        .pending_cnt(p_pend), .stall_cycles(p_sc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    stall;
        int    fwd;
        int    pend;
        int    sc;
        int    sc2;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_sc2 = -1;

    task automatic chk(string nm, string fld, int act, int expv);
        if (expv >= 0) begin
            n_vec++;
            if (act != expv) begin
                n_err++;
                $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, expv);
            end
        end
    endtask

    // Monitor: compare the expected response for this cycle, plus the W-alignment invariant.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.nm, "stall_D", int'(stall_D), e.stall);
            chk(e.nm, "ForwardID", int'(ForwardID), e.fwd);
            chk(e.nm, "pending_cnt", int'(pending_cnt), e.pend);
            chk(e.nm, "stall_cycles", int'(stall_cycles), e.sc);
            chk(e.nm, "stall_cycles_p4", int'(p_sc), e.sc2);
        end
        for (int r = 1; r < 32; r++) begin
            if (dut.cnt[r] == 3'd1) begin
                n_vec++;
                if (!(RegWrite_W && rd_W == 5'(r))) begin
                    n_err++;
                    $display("FAIL w_align: cnt[%0d]==1 but RegWrite_W=%0d rd_W=%0d", r, RegWrite_W, rd_W);
                end
            end
            if (dut2.cnt[r] == 5'd1) begin
                n_vec++;
                if (!(p_rww && p_rdw == 5'(r))) begin
                    n_err++;
                    $display("FAIL w_align_p: cnt[%0d]==1 but RegWrite_W=%0d rd_W=%0d", r, p_rww, p_rdw);
                end
            end
        end
    end

    task automatic idle();
        issue_valid_D = 0; reg_write_D = 0; rd_D = 0; lat_D = 0; rs_D = 0;
        rs_used_D = 0; flush_D = 0; RegWrite_W = 0; rd_W = 0;
        p_iv = 0; p_rw = 0; p_rd = 0; p_lat = 0; p_rs = 0; p_used = 0;
        p_fl = 0; p_rww = 0; p_rdw = 0;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [2:0] lat);
        issue_valid_D = 1; reg_write_D = 1; rd_D = rd; lat_D = lat;
    endtask

    task automatic src(input logic [4:0] a, input logic [4:0] b, input logic [1:0] used);
        issue_valid_D = 1; rs_D = {b, a}; rs_used_D = used;
    endtask

    task automatic wb(input logic [4:0] rd);
        RegWrite_W = 1; rd_W = rd;
    endtask

    task automatic step(string nm, int st, int fw, int pd, int sc);
        exp_t e;
        e.nm = nm; e.stall = st; e.fwd = fw; e.pend = pd; e.sc = sc; e.sc2 = exp_sc2;
        q.push_back(e);
        exp_sc2 = -1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;

        // reset: bypass forced off even with a matching W
        idle(); wb(3); src(3, 0, 2'b01);           step("rst_fwd", 0, 0, 0, 0);
        rst = 0;
        idle(); wb(3); src(3, 0, 2'b01);           step("fwd_basic", 0, 1, 0, 0);

        // load to x5, lat 3
        idle(); wr(5, 3);                          step("ld_issue", 0, 0, 0, 0);
        idle(); src(5, 0, 2'b01);                  step("raw_t1", 1, 0, 1, 0);
        idle(); src(5, 0, 2'b01);                  step("raw_t2", 1, 0, 1, 1);
        idle(); src(5, 5, 2'b11); wb(5);           step("raw_t3", 0, 3, 1, 2);
        idle();                                    step("drain_t4", 0, 0, 0, 2);

        // bypass qualifiers
        idle(); src(0, 6, 2'b11); wb(0);           step("fwd_rdw0", 0, 0, 0, 2);
        idle(); src(6, 6, 2'b01); wb(6);           step("fwd_unused", 0, 1, 0, 2);

        // x0 never tracked, lat 0 never tracked
        idle(); wr(0, 3); src(0, 0, 2'b11);        step("rd0_issue", 0, 0, 0, 2);
        idle(); src(0, 0, 2'b11);                  step("rd0_after", 0, 0, 0, 2);
        idle(); wr(4, 0);                          step("lat0_issue", 0, 0, 0, 2);
        idle(); src(4, 0, 2'b01);                  step("lat0_use", 0, 0, 0, 2);

        // WAW on x7
        idle(); wr(7, 3);                          step("waw_first", 0, 0, 0, 2);
        idle(); wr(7, 1);                          step("waw_stall1", 1, 0, 1, 2);
        idle(); wr(7, 1);                          step("waw_stall2", 1, 0, 1, 3);
        idle(); wr(7, 1); wb(7);                   step("waw_issue", 0, 0, 1, 4);
        idle(); src(7, 0, 2'b01); wb(7);           step("waw_done", 0, 1, 1, 4);
        idle(); src(7, 0, 2'b01);                  step("waw_clear", 0, 0, 0, 4);

        // latency above MAX_LAT clamps to 4
        idle(); wr(3, 7);                          step("clamp_issue", 0, 0, 0, 4);
        idle(); src(3, 0, 2'b01);                  step("clamp_s1", 1, 0, 1, 4);
        idle(); src(3, 0, 2'b01);                  step("clamp_s2", 1, 0, 1, 5);
        idle(); src(3, 0, 2'b01);                  step("clamp_s3", 1, 0, 1, 6);
        idle(); src(3, 0, 2'b01); wb(3);           step("clamp_w", 0, 1, 1, 7);
        idle();                                    step("clamp_clear", 0, 0, 0, 7);

        // flush of a stalled instruction
        idle(); wr(9, 4);                          step("fl_issue", 0, 0, 0, 7);
        idle(); wr(10, 2); src(9, 0, 2'b01); flush_D = 1;
                                                   step("fl_kill", 0, 0, 1, 7);
        idle(); src(10, 0, 2'b01);                 step("fl_noload", 0, 0, 1, 7);
        idle(); src(9, 0, 2'b01);                  step("fl_older", 1, 0, 1, 7);
        idle(); src(9, 0, 2'b01); wb(9);           step("fl_w", 0, 1, 1, 8);
        idle();                                    step("fl_clear", 0, 0, 0, 8);

        // reset with three pending entries
        idle(); wr(11, 4);                         step("rs_i11", 0, 0, 0, 8);
        idle(); wr(12, 4);                         step("rs_i12", 0, 0, 1, 8);
        idle(); wr(13, 4);                         step("rs_i13", 0, 0, 2, 8);
        idle();                                    step("rs_pend3", 0, 0, 3, 8);
        rst = 1;
        idle(); src(12, 13, 2'b11); wb(12);        step("rs_hold", 0, 0, 0, 0);
        rst = 0;
        idle(); src(12, 13, 2'b11);                step("rs_after", 0, 0, 0, 0);
        idle(); src(11, 0, 2'b01);                 step("rs_after2", 0, 0, 0, 0);

        // 4-bit perf counter saturation: x1 with lat 25 gives 24 stall cycles
        idle(); p_iv = 1; p_rw = 1; p_rd = 5'd1; p_lat = 5'd25;
        exp_sc2 = 0;                               step("pf_issue", 0, 0, 0, 0);
        for (int k = 1; k <= 24; k++) begin
            idle(); p_iv = 1; p_rs = {5'd0, 5'd1}; p_used = 2'b01;
            exp_sc2 = (k - 1 > 15) ? 15 : k - 1;
            step($sformatf("pf_%0d", k), 0, 0, 0, 0);
        end
        idle(); p_iv = 1; p_rs = {5'd0, 5'd1}; p_used = 2'b01; p_rww = 1; p_rdw = 5'd1;
        exp_sc2 = 15;                              step("pf_w", 0, 0, 0, 0);
        idle(); exp_sc2 = 15;                      step("pf_hold", 0, 0, 0, 0);

        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d unchecked entries expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
